// File: rtl/sdc_cmd_sched.sv
// sdc_cmd_sched: round-robin SD command scheduler with CRC7 framing and response-owner tag FIFO
module sdc_cmd_sched #(
    parameter int NREQ = 2,
    parameter int MAX_OUT = 4,
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1,
    localparam int CW = $clog2(MAX_OUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [6*NREQ-1:0]    req_index,
    input  logic [32*NREQ-1:0]   req_arg,
    input  logic [2*NREQ-1:0]    req_resp,
    output logic [NREQ-1:0]      req_ready,
    output logic [7:0]           cmd_data,
    output logic                 cmd_valid,
    input  logic                 cmd_full,
    input  logic                 resp_done,
    output logic [IW-1:0]        resp_owner,
    output logic                 resp_pend,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, CRC, HDR, BODY} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] rr_q, g;
    logic [5:0] ctr_q, ctr_d, index_q;
    logic [6:0] crc_q, crc_d;
    logic [31:0] arg_q;
    logic [1:0] resp_q, g_resp;
    logic [IW-1:0] tag_q [MAX_OUT];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic found, accept, push, pop, fb;
    logic [39:0] frame;
    logic [7:0] body;
    int idx;

    always_comb begin
        found = 1'b0;
        g = '0;
        idx = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx -= NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                g = IW'(idx);
            end
        end
    end

    // A full tag FIFO stalls the rr winner rather than skipping it
    assign g_resp = req_resp[2*g +: 2];
    assign accept = state_q == IDLE && found && !(g_resp != 2'b00 && cnt_q == CW'(MAX_OUT));
    assign push = accept && g_resp != 2'b00;
    assign pop = resp_done && cnt_q != '0;
    assign req_ready = accept ? NREQ'(1) << g : '0;

    assign frame = {2'b01, index_q, arg_q};
    assign fb = crc_q[6] ^ frame[6'd39 - ctr_q];
    assign body = ctr_q == 6'd0 ? {2'b01, index_q} :
                  ctr_q == 6'd1 ? arg_q[31:24] :
                  ctr_q == 6'd2 ? arg_q[23:16] :
                  ctr_q == 6'd3 ? arg_q[15:8] :
                  ctr_q == 6'd4 ? arg_q[7:0] : {crc_q, 1'b1};
    assign cmd_valid = (state_q == HDR || state_q == BODY) && !cmd_full;
    assign cmd_data = state_q == HDR ? {6'b000100, resp_q == 2'd3 ? 2'd1 : resp_q} :
                      state_q == BODY ? body : 8'h00;
    assign busy = state_q != IDLE;
    assign resp_pend = cnt_q != '0;
    assign resp_owner = resp_pend ? tag_q[rp_q] : '0;

    always_comb begin
        state_d = state_q;
        ctr_d = ctr_q;
        crc_d = crc_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = CRC;
                ctr_d = '0;
                crc_d = '0;
            end
            CRC: begin
                crc_d = {crc_q[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
                ctr_d = ctr_q == 6'd39 ? 6'd0 : ctr_q + 6'd1;
                state_d = ctr_q == 6'd39 ? HDR : CRC;
            end
            HDR: state_d = cmd_valid ? BODY : HDR;
            BODY: if (cmd_valid) begin
                ctr_d = ctr_q + 6'd1;
                state_d = ctr_q == 6'd5 ? IDLE : BODY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q <= IW'(NREQ - 1);
            ctr_q <= '0;
            crc_q <= '0;
            cnt_q <= '0;
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            state_q <= state_d;
            ctr_q <= ctr_d;
            crc_q <= crc_d;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            if (accept) rr_q <= g;
            if (push) begin
                tag_q[wp_q] <= g;
                wp_q <= wp_q == PW'(MAX_OUT - 1) ? '0 : wp_q + 1'b1;
            end
            if (pop) rp_q <= rp_q == PW'(MAX_OUT - 1) ? '0 : rp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            index_q <= req_index[6*g +: 6];
            arg_q <= req_arg[32*g +: 32];
            resp_q <= g_resp;
        end
    end
endmodule

// File: tb/tb_sdc_cmd_sched.sv
// tb_sdc_cmd_sched: vector table, corner sequences and randomized model check for sdc_cmd_sched
module tb_sdc_cmd_sched;
    localparam int N = 2;
    localparam int MAX_OUT = 4;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [6*N-1:0] req_index = '0;
    logic [32*N-1:0] req_arg = '0;
    logic [2*N-1:0] req_resp = '0;
    logic [N-1:0] req_ready;
    logic [7:0] cmd_data;
    logic cmd_valid;
    logic cmd_full = 1'b0;
    logic resp_done = 1'b0;
    logic [IW-1:0] resp_owner;
    logic resp_pend, busy;

    sdc_cmd_sched #(.NREQ(N), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_index(req_index),
        .req_arg(req_arg), .req_resp(req_resp), .req_ready(req_ready),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_full(cmd_full),
        .resp_done(resp_done), .resp_owner(resp_owner), .resp_pend(resp_pend), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    typedef struct { logic [7:0] d; int c; } byte_t;
    byte_t bq[$];
    int gq_id[$], gq_c[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) begin
                chk("valid_while_full", cmd_full, 0);
                bq.push_back('{cmd_data, cyc});
            end
            for (int r = 0; r < N; r++)
                if (req_ready[r]) begin
                    gq_id.push_back(r);
                    gq_c.push_back(cyc);
                end
        end
    end

    // Record by CRC7 polynomial long division, independent of any shift register
    function automatic logic [55:0] rec_of(input logic [5:0] ix, input logic [31:0] a, input logic [1:0] rs);
        logic [46:0] m;
        m = {2'b01, ix, a, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (m[i]) m = m ^ (47'h89 << (i - 7));
        return {6'b000100, rs == 2'd3 ? 2'd1 : rs, 2'b01, ix, a, m[6:0], 1'b1};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int r, input logic [5:0] ix, input logic [31:0] a, input logic [1:0] rs);
        req_index[6*r +: 6] = ix;
        req_arg[32*r +: 32] = a;
        req_resp[2*r +: 2] = rs;
        req_valid[r] = 1'b1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req_valid = '0;
        cmd_full = 1'b0;
        resp_done = 1'b0;
        step(2);
        rst = 1'b0;
        bq.delete();
        gq_id.delete();
        gq_c.delete();
    endtask

    task automatic wait_grant(input int lim, output int id, output int c);
        bit got;
        got = 1'b0;
        id = -1;
        c = 0;
        for (int k = 0; k < lim && !got; k++) begin
            step(1);
            if (gq_id.size() > 0) begin
                got = 1'b1;
                id = gq_id.pop_front();
                c = gq_c.pop_front();
            end
        end
        chk("grant_seen", got, 1);
    endtask

    task automatic wait_bytes(input int n, input int lim);
        for (int k = 0; k < lim && bq.size() < n; k++) step(1);
        chk("bytes_seen", bq.size() >= n, 1);
    endtask

    task automatic check_rec(input string nm, input logic [55:0] exp, input int c0, input int lat);
        byte_t b;
        for (int j = 0; j < 7; j++)
            if (bq.size() > 0) begin
                b = bq.pop_front();
                chk($sformatf("%s_b%0d", nm, j), b.d, exp[55-8*j -: 8]);
                if (j == 0) chk({nm, "_hdr_lat"}, b.c - c0, 41);
                if (j == 6) chk({nm, "_last_lat"}, b.c - c0, lat);
            end
    endtask

    task automatic issue(input int r, input logic [5:0] ix, input logic [1:0] rs, output int id);
        int c;
        drive(r, ix, 32'h0, rs);
        wait_grant(4, id, c);
        req_valid = '0;
        wait_bytes(7, 60);
        bq.delete();
    endtask

    task automatic pulse_done;
        resp_done = 1'b1;
        step(1);
        resp_done = 1'b0;
    endtask

    typedef struct { int r; logic [5:0] ix; logic [31:0] a; logic [1:0] rs; logic [55:0] exp; } vec_t;
    vec_t tv[6];

    initial begin
        int id, c, cp;
        int m_rr, m_ci, m_k, w;
        int oq[$];
        int own[3];
        bit m_busy, acc;
        logic [1:0] wr;
        logic [55:0] m_rec;
        tv[0] = '{0, 6'd0, 32'h0, 2'd0, 56'h10_40_00_00_00_00_95};
        tv[1] = '{1, 6'd8, 32'h1AA, 2'd1, 56'h11_48_00_00_01_AA_87};
        tv[2] = '{0, 6'd17, 32'h0, 2'd1, 56'h11_51_00_00_00_00_55};
        tv[3] = '{1, 6'd55, 32'h0, 2'd1, 56'h11_77_00_00_00_00_65};
        tv[4] = '{0, 6'd41, 32'h4000_0000, 2'd3, 56'h11_69_40_00_00_00_77};
        tv[5] = '{1, 6'd2, 32'h0, 2'd2, 56'h12_42_00_00_00_00_4D};

        do_reset;
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_data", cmd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pend", resp_pend, 0);
        chk("rst_owner", resp_owner, 0);
        step(1);

        foreach (tv[i]) begin
            drive(tv[i].r, tv[i].ix, tv[i].a, tv[i].rs);
            wait_grant(4, id, c);
            req_valid = '0;
            chk("tv_grant", id, tv[i].r);
            chk("tv_pend", resp_pend, tv[i].rs != 0);
            chk("tv_owner", resp_owner, tv[i].rs != 0 ? tv[i].r : 0);
            wait_bytes(7, 60);
            check_rec($sformatf("tv%0d", i), tv[i].exp, c, 47);
            if (tv[i].rs != 0) pulse_done;
            chk("tv_pend_clr", resp_pend, 0);
        end

        // Two requesters always valid: strict alternation, one accept per 48 cycles
        do_reset;
        drive(0, 6'd1, 32'h0, 2'd0);
        drive(1, 6'd2, 32'h0, 2'd0);
        for (int k = 0; k < 4*48 + 20 && gq_id.size() < 4; k++) step(1);
        req_valid = '0;
        chk("t3_count", gq_id.size(), 4);
        cp = 0;
        for (int j = 0; j < 4; j++)
            if (gq_id.size() > 0) begin
                id = gq_id.pop_front();
                c = gq_c.pop_front();
                chk("t3_order", id, j % 2);
                if (j > 0) chk("t3_gap", c - cp, 48);
                cp = c;
            end
        wait_bytes(28, 80);
        step(10);
        chk("t3_bytes", bq.size(), 28);
        bq.delete();

        // Queue full for 5 cycles mid-body
        drive(0, 6'd17, 32'h0, 2'd1);
        wait_grant(4, id, c);
        req_valid = '0;
        for (int k = 0; k < 60 && bq.size() < 3; k++) step(1);
        cmd_full = 1'b1;
        step(5);
        cmd_full = 1'b0;
        wait_bytes(7, 30);
        step(3);
        chk("t4_count", bq.size(), 7);
        check_rec("t4", 56'h11_51_00_00_00_00_55, c, 52);
        pulse_done;

        // Tag FIFO: fill, block, unblock, coincident push/pop, pop at empty
        do_reset;
        for (int i = 0; i < 4; i++) begin
            issue(i % 2, 6'd17, 2'd1, id);
            chk("t5_fill_grant", id, i % 2);
        end
        chk("t5_pend", resp_pend, 1);
        chk("t5_owner0", resp_owner, 0);
        drive(0, 6'd17, 32'h0, 2'd1);
        step(60);
        chk("t5_blocked", gq_id.size(), 0);
        chk("t5_idle", busy, 0);
        pulse_done;
        wait_grant(3, id, c);
        req_valid = '0;
        chk("t5_unblock", id, 0);
        chk("t5_owner1", resp_owner, 1);
        wait_bytes(7, 60);
        bq.delete();
        pulse_done;
        chk("t5_owner_pop", resp_owner, 0);
        drive(1, 6'd13, 32'h0, 2'd1);
        resp_done = 1'b1;
        step(1);
        resp_done = 1'b0;
        req_valid = '0;
        chk("t5_coinc_grant", gq_id.size(), 1);
        gq_id.delete();
        gq_c.delete();
        chk("t5_coinc_owner", resp_owner, 1);
        wait_bytes(7, 60);
        bq.delete();
        own = '{1, 0, 1};
        for (int j = 0; j < 3; j++) begin
            chk("t5_drain_pend", resp_pend, 1);
            chk("t5_drain_owner", resp_owner, own[j]);
            pulse_done;
        end
        chk("t5_empty_pend", resp_pend, 0);
        pulse_done;
        chk("t5_extra_pend", resp_pend, 0);
        chk("t5_extra_owner", resp_owner, 0);
        issue(1, 6'd8, 2'd1, id);
        chk("t5_after_pend", resp_pend, 1);
        chk("t5_after_owner", resp_owner, 1);
        pulse_done;
        chk("t5_final_pend", resp_pend, 0);

        // Reset in the middle of the body
        drive(0, 6'd17, 32'h1234_5678, 2'd1);
        wait_grant(4, id, c);
        req_valid = '0;
        for (int k = 0; k < 60 && bq.size() < 3; k++) step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_valid", cmd_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_pend", resp_pend, 0);
        bq.delete();
        gq_id.delete();
        gq_c.delete();
        step(1);
        drive(0, 6'd3, 32'h0, 2'd0);
        drive(1, 6'd4, 32'h0, 2'd0);
        wait_grant(4, id, c);
        req_valid = '0;
        chk("t6_winner", id, 0);
        wait_bytes(7, 60);

        // Randomized run against the reference model
        do_reset;
        m_rr = N - 1;
        m_busy = 1'b0;
        m_ci = 0;
        m_k = 0;
        m_rec = '0;
        for (int t = 0; t < 6000; t++) begin
            @(posedge clk);
            #1;
            cmd_full = ($urandom_range(2) == 0);
            resp_done = ($urandom_range(95) == 0);
            req_valid = N'($urandom);
            for (int r = 0; r < N; r++) begin
                req_index[6*r +: 6] = 6'($urandom);
                req_arg[32*r +: 32] = $urandom;
                req_resp[2*r +: 2] = 2'($urandom);
            end
            @(negedge clk);
            w = -1;
            acc = 1'b0;
            wr = 2'd0;
            if (!m_busy)
                for (int k = 1; k <= N; k++)
                    if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
            if (w >= 0) begin
                wr = req_resp[2*w +: 2];
                acc = !(wr != 0 && oq.size() == MAX_OUT);
            end
            chk("rnd_ready", req_ready, acc ? (1 << w) : 0);
            chk("rnd_busy", busy, m_busy);
            chk("rnd_valid", cmd_valid, m_busy && m_ci >= 41 && !cmd_full);
            if (m_busy && m_ci >= 41) chk("rnd_data", cmd_data, m_rec[55-8*m_k -: 8]);
            chk("rnd_pend", resp_pend, oq.size() != 0);
            chk("rnd_owner", resp_owner, oq.size() != 0 ? oq[0] : 0);
            if (resp_done && oq.size() > 0) void'(oq.pop_front());
            if (acc && wr != 0) oq.push_back(w);
            if (acc) begin
                m_rec = rec_of(req_index[6*w +: 6], req_arg[32*w +: 32], wr);
                m_busy = 1'b1;
                m_ci = 1;
                m_k = 0;
                m_rr = w;
            end else if (m_busy) begin
                if (m_ci >= 41 && !cmd_full) m_k++;
                if (m_k == 7) m_busy = 1'b0;
                m_ci++;
            end
        end
        req_valid = '0;
        cmd_full = 1'b0;
        resp_done = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
